// File: rtl/hmac_pkg.sv
// Shared types, sizes and helpers for the HMAC message framer.
package hmac_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * 8;
  localparam int unsigned WORD_W      = WORD_BYTES * 8;
  localparam int unsigned KEY_W       = 256;
  localparam int unsigned TAG_W       = 256;
  localparam int unsigned LEN_W       = 32;
  // Wide enough for BLOCK_BYTES + WORD_BYTES before saturation.
  localparam int unsigned CNT_W       = 7;
  localparam int unsigned KCNT_W      = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    EMIT    = 2'd3
  } framer_state_t;

  typedef struct packed {
    logic             trunc;
    logic [TAG_W-1:0] data;
  } tag_t;

  // Number of kept bytes for an MSB-first contiguous keep mask.
  function automatic logic [KCNT_W-1:0] keep_to_count(input logic [WORD_BYTES-1:0] keep);
    logic [KCNT_W-1:0] n;
    case (keep)
      4'hF:    n = KCNT_W'(4);
      4'hE:    n = KCNT_W'(3);
      4'hC:    n = KCNT_W'(2);
      4'h8:    n = KCNT_W'(1);
      default: n = KCNT_W'(0);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/hmac_beat_packer.sv
// Packs kept beat bytes into the 512-bit message buffer at the running
// byte offset; saturates the count at the block size and flags overflow.
module hmac_beat_packer
  import hmac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  beat_i,
  input  logic                  clear_i,
  input  logic [WORD_W-1:0]     data_i,
  input  logic [WORD_BYTES-1:0] keep_i,
  output logic [BLOCK_W-1:0]    buf_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  trunc_o
);

  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trunc_q, trunc_d;
  logic [KCNT_W-1:0]  n_kept;
  logic [CNT_W-1:0]   sum;
  logic [CNT_W-1:0]   pos;

  // Byte-offset write, count saturation and overflow flag.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    pos     = '0;
    n_kept  = keep_to_count(keep_i);
    sum     = cnt_q + CNT_W'(n_kept);
    if (clear_i) begin
      buf_d   = '0;
      cnt_d   = '0;
      trunc_d = 1'b0;
    end else if (beat_i) begin
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
        pos = cnt_q + CNT_W'(k);
        if ((k < 32'(n_kept)) && (pos < CNT_W'(BLOCK_BYTES))) begin
          buf_d[(BLOCK_BYTES - 1 - 32'(pos)) * 8 +: 8] = data_i[(WORD_BYTES - 1 - k) * 8 +: 8];
        end
      end
      if (sum > CNT_W'(BLOCK_BYTES)) begin
        cnt_d   = CNT_W'(BLOCK_BYTES);
        trunc_d = 1'b1;
      end else begin
        cnt_d = sum;
      end
    end
  end

  // Buffer, count and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign buf_o   = buf_q;
  assign cnt_o   = cnt_q;
  assign trunc_o = trunc_q;

endmodule

// File: rtl/hmac_msg_framer.sv
// Frames a byte stream into one 512-bit block, launches one HMAC
// operation per frame with a per-frame constant key, and returns the tag.
module hmac_msg_framer
  import hmac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_W-1:0]     s_data,
  input  logic [WORD_BYTES-1:0] s_keep,
  input  logic                  s_last,
  input  logic [KEY_W-1:0]      key_in,
  input  logic                  key_load,
  output logic                  hm_start,
  output logic [BLOCK_W-1:0]    hm_message,
  output logic [LEN_W-1:0]      hm_length,
  output logic [KEY_W-1:0]      hm_key,
  input  logic                  hm_busy,
  input  logic                  hm_done,
  input  logic [TAG_W-1:0]      hm_hmac,
  output logic                  tag_valid,
  input  logic                  tag_ready,
  output logic [TAG_W-1:0]      tag_data,
  output logic                  tag_trunc
);

  framer_state_t         state_q, state_d;
  logic                  s_ready_q, s_ready_d;
  logic                  hm_start_q, hm_start_d;
  logic                  tag_valid_q, tag_valid_d;
  logic [KEY_W-1:0]      key_q;
  tag_t                  tag_q;

  logic                  beat_fire;
  logic                  tag_fire;
  logic [WORD_BYTES-1:0] eff_keep;
  logic [BLOCK_W-1:0]    pk_buf;
  logic [CNT_W-1:0]      pk_cnt;
  logic                  pk_trunc;
  logic                  unused_busy;

  // Engine busy is observed for debug only.
  assign unused_busy = hm_busy;

  // s_ready_q is only high in COLLECT, so it alone qualifies acceptance.
  assign beat_fire = s_valid && s_ready_q;
  assign tag_fire  = tag_valid_q && tag_ready;
  assign eff_keep  = s_last ? s_keep : '1;

  hmac_beat_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .beat_i  (beat_fire),
    .clear_i (tag_fire),
    .data_i  (s_data),
    .keep_i  (eff_keep),
    .buf_o   (pk_buf),
    .cnt_o   (pk_cnt),
    .trunc_o (pk_trunc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (beat_fire && s_last) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (hm_done) state_d = EMIT;
      EMIT:    if (tag_fire) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Handshake outputs decoded from the next state so they register in step.
  always_comb begin
    s_ready_d   = (state_d == COLLECT);
    hm_start_d  = (state_d == ISSUE);
    tag_valid_d = (state_d == EMIT);
  end

  // Handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q   <= 1'b0;
      hm_start_q  <= 1'b0;
      tag_valid_q <= 1'b0;
    end else begin
      s_ready_q   <= s_ready_d;
      hm_start_q  <= hm_start_d;
      tag_valid_q <= tag_valid_d;
    end
  end

  // Key captured only between frames so it cannot change under a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if (key_load && (state_q == COLLECT) && (pk_cnt == '0) && !beat_fire) begin
      key_q <= key_in;
    end
  end

  // Tag and truncation flag captured on engine completion while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else if ((state_q == WAIT) && hm_done) begin
      tag_q.data  <= hm_hmac;
      tag_q.trunc <= pk_trunc;
    end
  end

  assign s_ready    = s_ready_q;
  assign hm_start   = hm_start_q;
  assign hm_message = pk_buf;
  assign hm_length  = LEN_W'(pk_cnt);
  assign hm_key     = key_q;
  assign tag_valid  = tag_valid_q;
  assign tag_data   = tag_q.data;
  assign tag_trunc  = tag_q.trunc;

endmodule

// File: tb/tb_hmac_msg_framer.sv
// Scoreboard bench for hmac_msg_framer with a simple engine model.
module tb_hmac_msg_framer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic [3:0]   s_keep;
  logic         s_last;
  logic [255:0] key_in;
  logic         key_load;
  logic         hm_start;
  logic [511:0] hm_message;
  logic [31:0]  hm_length;
  logic [255:0] hm_key;
  logic         hm_busy;
  logic         hm_done;
  logic [255:0] hm_hmac;
  logic         tag_valid;
  logic         tag_ready;
  logic [255:0] tag_data;
  logic         tag_trunc;

  localparam int ENG_LAT = 6;

  typedef struct {
    logic [31:0]  len;
    logic [511:0] msg;
    logic [255:0] key;
  } launch_t;

  typedef struct {
    logic [255:0] data;
    logic         trunc;
  } tag_exp_t;

  launch_t  launch_q[$];
  tag_exp_t tag_q[$];
  launch_t  le;
  tag_exp_t te;
  int       n_checks = 0;
  int       n_pass   = 0;
  logic [255:0] eng_tag = '0;

  localparam logic [255:0] KEY_A = {8{32'hA0A1A2A3}};
  localparam logic [255:0] KEY_B = {8{32'hB0B1B2B3}};

  always #5 clk = ~clk;

  hmac_msg_framer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_keep     (s_keep),
    .s_last     (s_last),
    .key_in     (key_in),
    .key_load   (key_load),
    .hm_start   (hm_start),
    .hm_message (hm_message),
    .hm_length  (hm_length),
    .hm_key     (hm_key),
    .hm_busy    (hm_busy),
    .hm_done    (hm_done),
    .hm_hmac    (hm_hmac),
    .tag_valid  (tag_valid),
    .tag_ready  (tag_ready),
    .tag_data   (tag_data),
    .tag_trunc  (tag_trunc)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event absent or unexpected", name);
  endtask

  // Engine model: answers each launch after a fixed latency.
  initial begin
    hm_done = 1'b0;
    hm_busy = 1'b0;
    hm_hmac = '0;
    forever begin
      @(negedge clk);
      if (hm_start) begin
        hm_busy = 1'b1;
        repeat (ENG_LAT) @(posedge clk);
        #1;
        hm_done = 1'b1;
        hm_hmac = eng_tag;
        @(posedge clk);
        #1;
        hm_done = 1'b0;
        hm_busy = 1'b0;
        hm_hmac = ~eng_tag;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT launches or hands over a tag.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && hm_start) begin
        if (launch_q.size() == 0) fail_now("unexpected_launch");
        else begin
          le = launch_q.pop_front();
          chk("launch_len", 512'(hm_length), 512'(le.len));
          chk("launch_msg", hm_message, le.msg);
          chk("launch_key", 512'(hm_key), 512'(le.key));
        end
      end
      if (rst_n && tag_valid && tag_ready) begin
        if (tag_q.size() == 0) fail_now("unexpected_tag");
        else begin
          te = tag_q.pop_front();
          chk("tag_data", 512'(tag_data), 512'(te.data));
          chk("tag_trunc", 512'(tag_trunc), 512'(te.trunc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic expect_frame(input logic [31:0] len, input logic [511:0] msg,
                              input logic [255:0] key, input logic [255:0] tag,
                              input logic trunc, input logic with_tag);
    launch_t  l;
    tag_exp_t t;
    l.len = len; l.msg = msg; l.key = key;
    launch_q.push_back(l);
    eng_tag = tag;
    if (with_tag) begin
      t.data = tag; t.trunc = trunc;
      tag_q.push_back(t);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t = 0;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) fail_now("beat_accept_timeout");
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
  endtask

  task automatic key_pulse(input logic [255:0] k);
    key_in = k; key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while (!(launch_q.size() == 0 && tag_q.size() == 0 && s_ready && !tag_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now({"idle_timeout_", name});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"},    512'(s_ready),    512'(0));
    chk({tag, "_hm_start"},   512'(hm_start),   512'(0));
    chk({tag, "_hm_message"}, hm_message,       512'(0));
    chk({tag, "_hm_length"},  512'(hm_length),  512'(0));
    chk({tag, "_hm_key"},     512'(hm_key),     512'(0));
    chk({tag, "_tag_valid"},  512'(tag_valid),  512'(0));
    chk({tag, "_tag_data"},   512'(tag_data),   512'(0));
    chk({tag, "_tag_trunc"},  512'(tag_trunc),  512'(0));
  endtask

  logic [511:0] msg_full;
  logic [7:0]   base;
  int           seen;
  int           wt;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    key_in = '0; key_load = 1'b0; tag_ready = 1'b1;
    for (int i = 0; i < 64; i++) msg_full[511 - 8*i -: 8] = 8'(i);

    // Reset values and s_ready rising on the first edge after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_before_edge", 512'(s_ready), 512'(0));
    @(negedge clk);
    chk("s_ready_after_edge", 512'(s_ready), 512'(1));
    @(posedge clk);
    #1;
    key_pulse(KEY_A);

    // Partial last beat; key B pulsed mid-frame must be ignored.
    expect_frame(32'd14, {112'h000102030405060708090A0B0C0D, 400'h0}, KEY_A,
                 {8{32'h7A600001}}, 1'b0, 1'b1);
    send_beat(32'h00010203, 4'hF, 1'b0);
    key_pulse(KEY_B);
    send_beat(32'h04050607, 4'hF, 1'b0);
    send_beat(32'h08090A0B, 4'hF, 1'b0);
    send_beat(32'h0C0D0E0F, 4'hC, 1'b1);
    @(negedge clk);
    chk("start_after_last", 512'(hm_start), 512'(1));
    chk("ready_drop_after_last", 512'(s_ready), 512'(0));
    @(negedge clk);
    chk("start_one_cycle", 512'(hm_start), 512'(0));
    @(negedge clk);
    chk("key_a_in_wait", 512'(hm_key), 512'(KEY_A));
    chk("len_held_in_wait", 512'(hm_length), 512'(14));
    wait_idle("f1");

    // Empty frame.
    expect_frame(32'd0, 512'(0), KEY_A, {8{32'h7A600002}}, 1'b0, 1'b1);
    send_beat(32'hDEADBEEF, 4'h0, 1'b1);
    wait_idle("f2");

    // 17 full beats: last four bytes dropped, truncation flagged.
    expect_frame(32'd64, msg_full, KEY_A, {8{32'h7A600003}}, 1'b1, 1'b1);
    for (int b = 0; b < 17; b++) begin
      base = 8'(4*b);
      send_beat({base, base + 8'd1, base + 8'd2, base + 8'd3}, 4'hF, b == 16);
    end
    wait_idle("f3");

    // Exactly 64 bytes: no truncation, and flag cleared from previous frame.
    expect_frame(32'd64, msg_full, KEY_A, {8{32'h7A600004}}, 1'b0, 1'b1);
    for (int b = 0; b < 16; b++) begin
      base = 8'(4*b);
      send_beat({base, base + 8'd1, base + 8'd2, base + 8'd3}, 4'hF, b == 15);
    end
    wait_idle("f4");

    // Tag back-pressure for 10 cycles.
    tag_ready = 1'b0;
    expect_frame(32'd5, {40'h1122334455, 472'h0}, KEY_A, {8{32'h7A600005}}, 1'b0, 1'b1);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'h8, 1'b1);
    wt = 0;
    @(negedge clk);
    while (!tag_valid && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    if (!tag_valid) fail_now("tag_valid_timeout");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_tag_data", 512'(tag_data), 512'({8{32'h7A600005}}));
      chk("hold_s_ready", 512'(s_ready), 512'(0));
    end
    @(posedge clk);
    #1 tag_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ready_after_handshake", 512'(s_ready), 512'(1));
    chk("valid_after_handshake", 512'(tag_valid), 512'(0));
    wait_idle("f5");

    // Reset while waiting on the engine.
    expect_frame(32'd4, {32'hCAFEF00D, 480'h0}, KEY_A, {8{32'h7A600006}}, 1'b0, 1'b0);
    send_beat(32'hCAFEF00D, 4'hF, 1'b1);
    wt = 0;
    while (launch_q.size() != 0 && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    if (launch_q.size() != 0) fail_now("launch_timeout");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("wait_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_before_edge", 512'(s_ready), 512'(0));
    @(negedge clk);
    chk("rst_ready_after_edge", 512'(s_ready), 512'(1));
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (tag_valid) seen++;
    end
    chk("no_tag_after_reset", 512'(seen), 512'(0));
    @(posedge clk);
    #1;

    // Fresh frame after reset with a newly loaded key.
    key_pulse(KEY_B);
    expect_frame(32'd4, {32'h12345678, 480'h0}, KEY_B, {8{32'h7A600007}}, 1'b0, 1'b1);
    send_beat(32'h12345678, 4'hF, 1'b1);
    wait_idle("f7");

    chk("queues_drained", 512'(launch_q.size() + tag_q.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hmac_msg_framer.md
# hmac_msg_framer

Upstream framing stage for the HMAC-SHA256 engine. It collects a byte-oriented message from a 32-bit valid/ready stream into a single 512-bit block with a byte length. It holds a registered 256-bit key, launches one HMAC operation per frame, and returns the 256-bit tag on a valid/ready output. One frame is in flight at a time; the stream is back-pressured while the engine works.

## Interface
Parameters:
- BLOCK_BYTES, 64: message capacity in bytes; fixed to the engine's 512-bit message port.
- WORD_BYTES, 4: bytes per input beat.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  32  beat data; byte 0 of the beat is [31:24].
- s_keep  in  4  byte enables, MSB-first contiguous (4'hF, 4'hE, 4'hC, 4'h8, 4'h0); honoured only on the last beat, treated as 4'hF otherwise.
- s_last  in  1  final beat of the frame.
- key_in  in  256  HMAC key.
- key_load  in  1  key capture strobe.
- hm_start  out  1  one-cycle launch pulse to the engine.
- hm_message  out  512  packed message; frame byte 0 is at [511:504]; unused bytes are 0.
- hm_length  out  32  frame length in bytes, 0..64.
- hm_key  out  256  registered key.
- hm_busy  in  1  engine busy; monitored only.
- hm_done  in  1  engine completion pulse.
- hm_hmac  in  256  engine tag, valid when hm_done.
- tag_valid  out  1  tag available.
- tag_ready  in  1  tag consumed when tag_valid && tag_ready.
- tag_data  out  256  captured tag.
- tag_trunc  out  1  frame exceeded 64 bytes and was truncated; qualified by tag_valid.

## Operation
States: COLLECT, ISSUE, WAIT, EMIT. Reset enters COLLECT.

- **COLLECT:**
  - Each accepted beat writes its kept bytes at the current byte_cnt offset, then byte_cnt += kept bytes.
  - Bytes at offset ≥ 64 are discarded and set trunc. byte_cnt saturates at 64.
  - The accepted s_last beat moves to ISSUE.
- **ISSUE:**
  - hm_start = 1 for exactly one cycle.
  - hm_length = byte_cnt.
  - Move to WAIT.
- **WAIT:**
  - hm_message, hm_length and hm_key are held stable.
  - On hm_done, capture hm_hmac into tag_data and trunc into tag_trunc, then move to EMIT.
  - hm_done in any other state is ignored.
- **EMIT:**
  - tag_valid = 1. tag_data and tag_trunc are held until the handshake.
  - On handshake: clear the message buffer, byte_cnt and trunc, then go to COLLECT.
- **Key capture:**
  - key_load captures key_in only in COLLECT with byte_cnt == 0 and no beat accepted that cycle.
  - key_load is ignored elsewhere, so the key is constant per frame.
- **Empty frame:** a last beat with s_keep = 0 and byte_cnt 0 gives hm_length 0 and an all-zero message.
- **Reset** (including mid-frame or mid-WAIT) clears all state. Any engine completion still in flight is ignored.

## Timing
Reset values:
- s_ready 0, hm_start 0, hm_message 0, hm_length 0, hm_key 0, tag_valid 0, tag_data 0, tag_trunc 0.
- s_ready is registered and rises on the first clk after rst_n deasserts.

Cycle behaviour:
- s_ready = 1 throughout COLLECT. It drops the cycle after s_last is accepted, so no extra beat is taken.
- s_last accepted at edge N: hm_start high N+1..N+2, WAIT from N+2.
- hm_done sampled at edge M: tag_valid high from M+1.
- Tag handshake at edge T: s_ready high from T+1.
- Throughput: one frame per (beats + engine latency + 3) cycles, minimum.

## Structure
- hmac_pkg holds:
  - BLOCK_BYTES, WORD_BYTES
  - the framer_state_t enum
  - the keep_to_count function.
- One sub-module, hmac_beat_packer: the byte-offset write into the 512-bit buffer plus the byte_cnt saturation and trunc logic.
- The framer keeps the FSM, the key register and the tag register.

## Test plan
- 3 full beats 0x00010203, 0x04050607, 0x08090A0B, then a last beat 0x0C0D0E0F with keep 4'hC:
  - hm_length 14
  - hm_message[511:400] = 0x000102…0D, rest 0
  - hm_start exactly one cycle after the last beat.
- Last beat only, keep 4'h0 → hm_length 0, hm_message 0, one hm_start, tag returned.
- 17 full beats → hm_length 64, bytes 64..67 absent, tag_trunc 1. The next frame has tag_trunc 0.
- Hold tag_ready 0 for 10 cycles after hm_done:
  - tag_data stable, s_ready 0 throughout
  - one handshake, then s_ready 1 the next cycle.
- key_load with key A, then key_load with key B pulsed mid-frame → hm_key = A during WAIT.
- Assert rst_n low in WAIT:
  - all outputs return to reset values
  - a later hm_done pulse produces no tag_valid
  - a new frame completes normally.
